// File: rtl/msrv32_instr_queue_mux_pkg.sv
// Shared RV32I constants for the instruction queue and the decode slice.
// Field positions, opcodes, the NOP word and the head-select priority live here.
package msrv32_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [6:0] OP_LOAD     = 7'h03;
    localparam logic [6:0] OP_MISC_MEM = 7'h0F;
    localparam logic [6:0] OP_IMM      = 7'h13;
    localparam logic [6:0] OP_AUIPC    = 7'h17;
    localparam logic [6:0] OP_STORE    = 7'h23;
    localparam logic [6:0] OP_REG      = 7'h33;
    localparam logic [6:0] OP_LUI      = 7'h37;
    localparam logic [6:0] OP_BRANCH   = 7'h63;
    localparam logic [6:0] OP_JALR     = 7'h67;
    localparam logic [6:0] OP_JAL      = 7'h6F;
    localparam logic [6:0] OP_SYSTEM   = 7'h73;

    localparam int OPCODE_MSB = 6;
    localparam int OPCODE_LSB = 0;
    localparam int RD_MSB     = 11;
    localparam int RD_LSB     = 7;
    localparam int FUNCT3_MSB = 14;
    localparam int FUNCT3_LSB = 12;
    localparam int RS1_MSB    = 19;
    localparam int RS1_LSB    = 15;
    localparam int RS2_MSB    = 24;
    localparam int RS2_LSB    = 20;
    localparam int FUNCT7_MSB = 31;
    localparam int FUNCT7_LSB = 25;
    localparam int CSR_MSB    = 31;
    localparam int CSR_LSB    = 20;

    // Flush beats an empty queue, which beats the stored head.
    typedef enum logic [1:0] {
        IQ_SEL_FLUSH = 2'd0,
        IQ_SEL_EMPTY = 2'd1,
        IQ_SEL_HEAD  = 2'd2
    } iq_sel_e;

    function automatic iq_sel_e iq_select(input logic flush, input logic empty);
        if (flush)      return IQ_SEL_FLUSH;
        else if (empty) return IQ_SEL_EMPTY;
        else            return IQ_SEL_HEAD;
    endfunction

    function automatic logic is_rv32i_opcode(input logic [6:0] op);
        return (op == OP_LOAD)  || (op == OP_MISC_MEM) || (op == OP_IMM)    ||
               (op == OP_AUIPC) || (op == OP_STORE)    || (op == OP_REG)    ||
               (op == OP_LUI)   || (op == OP_BRANCH)   || (op == OP_JALR)   ||
               (op == OP_JAL)   || (op == OP_SYSTEM);
    endfunction

endpackage

// File: rtl/msrv32_instr_queue_mux_if.sv
// Fetch-side push and decode-side pop bundle of the instruction queue.
// Optional illegal_out exists only with MSRV32_IQ_ILLEGAL_CHECK_EN defined.
interface msrv32_instr_queue_mux_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
);
    // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
    // valid never waits for ready, and flush_in drops both readies/valids that cycle.
    logic                     flush_in;
    logic                     push_valid_in;
    logic [XLEN-1:0]          push_instr_in;
    logic [XLEN-1:0]          push_pc_in;
    logic                     push_ready_out;
    logic                     pop_valid_out;
    logic                     pop_ready_in;
    logic [XLEN-1:0]          pc_out;
    logic [6:0]               opcode_out;
    logic [2:0]               funct3_out;
    logic [6:0]               funct7_out;
    logic [4:0]               rs1addr_out;
    logic [4:0]               rs2addr_out;
    logic [4:0]               rdaddr_out;
    logic [11:0]              csr_addr_out;
    logic [24:0]              instr_out;
    logic [$clog2(DEPTH):0]   count_out;
`ifdef MSRV32_IQ_ILLEGAL_CHECK_EN
    logic                     illegal_out;
`endif

    modport slave (
        input  flush_in, push_valid_in, push_instr_in, push_pc_in, pop_ready_in,
        output push_ready_out, pop_valid_out, pc_out, opcode_out, funct3_out,
               funct7_out, rs1addr_out, rs2addr_out, rdaddr_out, csr_addr_out,
               instr_out, count_out
`ifdef MSRV32_IQ_ILLEGAL_CHECK_EN
        , output illegal_out
`endif
    );

    modport master (
        output flush_in, push_valid_in, push_instr_in, push_pc_in, pop_ready_in,
        input  push_ready_out, pop_valid_out, pc_out, opcode_out, funct3_out,
               funct7_out, rs1addr_out, rs2addr_out, rdaddr_out, csr_addr_out,
               instr_out, count_out
`ifdef MSRV32_IQ_ILLEGAL_CHECK_EN
        , input illegal_out
`endif
    );

endinterface

// File: rtl/msrv32_instr_field_split.sv
// Pure combinational slicing of one RV32 instruction word into its decode fields.
module msrv32_instr_field_split
    import msrv32_pkg::*;
(
    input  logic [31:0] i_instr,
    output logic [6:0]  o_opcode,
    output logic [2:0]  o_funct3,
    output logic [6:0]  o_funct7,
    output logic [4:0]  o_rs1addr,
    output logic [4:0]  o_rs2addr,
    output logic [4:0]  o_rdaddr,
    output logic [11:0] o_csr_addr,
    output logic [24:0] o_instr
);

    assign o_opcode   = i_instr[OPCODE_MSB:OPCODE_LSB];
    assign o_funct3   = i_instr[FUNCT3_MSB:FUNCT3_LSB];
    assign o_funct7   = i_instr[FUNCT7_MSB:FUNCT7_LSB];
    assign o_rs1addr  = i_instr[RS1_MSB:RS1_LSB];
    assign o_rs2addr  = i_instr[RS2_MSB:RS2_LSB];
    assign o_rdaddr   = i_instr[RD_MSB:RD_LSB];
    assign o_csr_addr = i_instr[CSR_MSB:CSR_LSB];
    assign o_instr    = i_instr[31:7];

endmodule

// File: rtl/msrv32_instr_queue_mux.sv
// Circular instruction/PC queue between fetch and decode; head is presented as split fields.
// Build option: MSRV32_IQ_ILLEGAL_CHECK_EN adds an illegal-opcode flag on the head.
module msrv32_instr_queue_mux
    import msrv32_pkg::*;
#(
    parameter int          XLEN      = 32,
    parameter int          DEPTH     = 4,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                 ms_riscv32_mp_clk_in,
    input  logic                 ms_riscv32_mp_rst_in,
    msrv32_instr_queue_mux_if.slave bus
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [XLEN-1:0] r_instr [DEPTH];
    logic [XLEN-1:0] r_pc    [DEPTH];
    logic [PW-1:0]   r_rd_ptr;
    logic [PW-1:0]   r_wr_ptr;
    logic [CW-1:0]   r_count;

    logic            w_empty;
    logic            w_full;
    logic            w_pop_valid;
    logic            w_push_ready;
    logic            w_push;
    logic            w_pop;
    iq_sel_e         w_sel;
    logic [31:0]     w_mux_instr;

    assign w_empty      = (r_count == '0);
    assign w_full       = (r_count == CW'(DEPTH));
    assign w_pop_valid  = !w_empty && !bus.flush_in;
    assign w_push_ready = !w_full && !bus.flush_in;
    assign w_push       = bus.push_valid_in && w_push_ready;
    assign w_pop        = w_pop_valid && bus.pop_ready_in;
    assign w_sel        = iq_select(bus.flush_in, w_empty);

    always_comb begin
        w_mux_instr = NOP_INSTR;
        if (w_sel == IQ_SEL_HEAD) begin
            w_mux_instr = r_instr[r_rd_ptr];
        end
    end

    assign bus.pop_valid_out  = w_pop_valid;
    assign bus.push_ready_out = w_push_ready;
    assign bus.count_out      = r_count;
    assign bus.pc_out         = w_pop_valid ? r_pc[r_rd_ptr] : '0;

    msrv32_instr_field_split u_field_split (
        .i_instr    (w_mux_instr),
        .o_opcode   (bus.opcode_out),
        .o_funct3   (bus.funct3_out),
        .o_funct7   (bus.funct7_out),
        .o_rs1addr  (bus.rs1addr_out),
        .o_rs2addr  (bus.rs2addr_out),
        .o_rdaddr   (bus.rdaddr_out),
        .o_csr_addr (bus.csr_addr_out),
        .o_instr    (bus.instr_out)
    );

`ifdef MSRV32_IQ_ILLEGAL_CHECK_EN
    assign bus.illegal_out = w_pop_valid &&
                             ((w_mux_instr[1:0] != 2'b11) || !is_rv32i_opcode(w_mux_instr[6:0]));
`endif

    // Storage carries no reset; stale slots are unreachable once the pointers are cleared.
    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (ms_riscv32_mp_rst_in && w_push) begin
            r_instr[r_wr_ptr] <= bus.push_instr_in;
            r_pc[r_wr_ptr]    <= bus.push_pc_in;
        end
    end

    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (!ms_riscv32_mp_rst_in) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (bus.flush_in) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_msrv32_instr_queue_mux.sv
// Randomized and directed bench for msrv32_instr_queue_mux against a queue-level model.
module tb_msrv32_instr_queue_mux;

  localparam int DEPTH = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;
  bit   model_known;
  logic [63:0] exp_q[$];
  logic [31:0] pc_ctr;

  msrv32_instr_queue_mux_if #(.XLEN(32), .DEPTH(DEPTH)) bus ();

  msrv32_instr_queue_mux #(.XLEN(32), .DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
    .ms_riscv32_mp_clk_in (clk),
    .ms_riscv32_mp_rst_in (rst_n),
    .bus                  (bus)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic legal_op(input logic [6:0] op);
    logic [6:0] ops [11];
    ops = '{7'h03, 7'h0F, 7'h13, 7'h17, 7'h23, 7'h33, 7'h37, 7'h63, 7'h67, 7'h6F, 7'h73};
    if (op[1:0] != 2'b11) return 1'b0;
    foreach (ops[i]) if (ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  // scoreboard: compare every visible output with the model at the falling edge
  task automatic settle();
    logic [31:0] ei;
    logic [31:0] ep;
    logic ev;
    logic er;
    int n;
    @(negedge clk);
    if (model_known) begin
      n  = exp_q.size();
      ev = (n != 0) && !bus.flush_in;
      er = (n != DEPTH) && !bus.flush_in;
      ei = ev ? exp_q[0][31:0] : NOP;
      ep = ev ? exp_q[0][63:32] : 32'h0;
      n_tests += 12;
      if (bus.pop_valid_out !== ev) begin n_fail++; $display("FAIL pop_valid got %0b exp %0b t=%0t", bus.pop_valid_out, ev, $time); end
      if (bus.push_ready_out !== er) begin n_fail++; $display("FAIL push_ready got %0b exp %0b t=%0t", bus.push_ready_out, er, $time); end
      if (bus.count_out !== 3'(n)) begin n_fail++; $display("FAIL count got %0d exp %0d t=%0t", bus.count_out, n, $time); end
      if (bus.pc_out !== ep) begin n_fail++; $display("FAIL pc got %h exp %h t=%0t", bus.pc_out, ep, $time); end
      if (bus.opcode_out !== ei[6:0]) begin n_fail++; $display("FAIL opcode got %h exp %h t=%0t", bus.opcode_out, ei[6:0], $time); end
      if (bus.funct3_out !== ei[14:12]) begin n_fail++; $display("FAIL funct3 got %h exp %h t=%0t", bus.funct3_out, ei[14:12], $time); end
      if (bus.funct7_out !== ei[31:25]) begin n_fail++; $display("FAIL funct7 got %h exp %h t=%0t", bus.funct7_out, ei[31:25], $time); end
      if (bus.rs1addr_out !== ei[19:15]) begin n_fail++; $display("FAIL rs1 got %h exp %h t=%0t", bus.rs1addr_out, ei[19:15], $time); end
      if (bus.rs2addr_out !== ei[24:20]) begin n_fail++; $display("FAIL rs2 got %h exp %h t=%0t", bus.rs2addr_out, ei[24:20], $time); end
      if (bus.rdaddr_out !== ei[11:7]) begin n_fail++; $display("FAIL rd got %h exp %h t=%0t", bus.rdaddr_out, ei[11:7], $time); end
      if (bus.csr_addr_out !== ei[31:20]) begin n_fail++; $display("FAIL csr got %h exp %h t=%0t", bus.csr_addr_out, ei[31:20], $time); end
      if (bus.instr_out !== ei[31:7]) begin n_fail++; $display("FAIL instr got %h exp %h t=%0t", bus.instr_out, ei[31:7], $time); end
`ifdef MSRV32_IQ_ILLEGAL_CHECK_EN
      n_tests++;
      if (bus.illegal_out !== (ev && !legal_op(ei[6:0]))) begin
        n_fail++; $display("FAIL illegal got %0b exp %0b t=%0t", bus.illegal_out, ev && !legal_op(ei[6:0]), $time);
      end
`endif
    end
  endtask

  // model update for the coming rising edge, then step past it
  task automatic advance();
    int n;
    bit push_f;
    bit pop_f;
    n = exp_q.size();
    if (!rst_n) begin
      exp_q.delete();
      model_known = 1'b1;
    end else if (bus.flush_in) begin
      exp_q.delete();
    end else begin
      push_f = bus.push_valid_in && (n != DEPTH);
      pop_f  = bus.pop_ready_in && (n != 0);
      if (pop_f)  void'(exp_q.pop_front());
      if (push_f) exp_q.push_back({bus.push_pc_in, bus.push_instr_in});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [31:0] instr, input logic [31:0] pc);
    bus.push_valid_in = 1'b1;
    bus.push_instr_in = instr;
    bus.push_pc_in    = pc;
    settle();
    advance();
    bus.push_valid_in = 1'b0;
  endtask

  task automatic clear_q();
    bus.flush_in = 1'b1;
    settle();
    advance();
    bus.flush_in = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.push_valid_in = 1'b1;
    bus.push_instr_in = 32'h00500093;
    bus.push_pc_in    = 32'h0;
    settle();
    advance();
    settle();
    n_tests += 4;
    if (bus.count_out !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", bus.count_out); end
    if (bus.pop_valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_pop_valid got %0b exp 0", bus.pop_valid_out); end
    if (bus.opcode_out !== 7'h13) begin n_fail++; $display("FAIL reset_opcode got %h exp 13", bus.opcode_out); end
    if (bus.pc_out !== 32'h0) begin n_fail++; $display("FAIL reset_pc got %h exp 0", bus.pc_out); end
    advance();
    rst_n = 1'b1;
    settle();
    n_tests++;
    if (bus.push_ready_out !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready got %0b exp 1", bus.push_ready_out); end
    advance();
    bus.push_valid_in = 1'b0;
    settle();
    n_tests++;
    if (bus.count_out !== 3'd1) begin n_fail++; $display("FAIL reset_release_push count got %0d exp 1", bus.count_out); end
    advance();
  endtask

  task automatic test_fill_drain();
    logic [31:0] tbl [4];
    tbl = '{32'h00500093, 32'h00A00113, 32'h002081B3, 32'h40208233};
    clear_q();
    bus.pop_ready_in = 1'b0;
    for (int i = 0; i < 4; i++) push_one(tbl[i], 32'(i * 4));
    bus.push_valid_in = 1'b1;
    bus.push_instr_in = 32'h00000013;
    settle();
    n_tests += 2;
    if (bus.push_ready_out !== 1'b0) begin n_fail++; $display("FAIL fill_ready got %0b exp 0", bus.push_ready_out); end
    if (bus.count_out !== 3'd4) begin n_fail++; $display("FAIL fill_count got %0d exp 4", bus.count_out); end
    advance();
    bus.push_valid_in = 1'b0;
    bus.pop_ready_in  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      settle();
      n_tests++;
      if (bus.rdaddr_out !== 5'(i + 1)) begin n_fail++; $display("FAIL drain_rd%0d got %0d exp %0d", i, bus.rdaddr_out, i + 1); end
      if (i == 3) begin
        n_tests++;
        if (bus.funct7_out !== 7'h20) begin n_fail++; $display("FAIL drain_funct7 got %h exp 20", bus.funct7_out); end
      end
      advance();
    end
    settle();
    advance();
    bus.pop_ready_in = 1'b0;
  endtask

  task automatic test_back_to_back();
    clear_q();
    bus.pop_ready_in = 1'b0;
    push_one($urandom, pc_ctr); pc_ctr += 4;
    push_one($urandom, pc_ctr); pc_ctr += 4;
    bus.pop_ready_in  = 1'b1;
    bus.push_valid_in = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.push_instr_in = $urandom;
      bus.push_pc_in    = pc_ctr; pc_ctr += 4;
      settle();
      n_tests++;
      if (bus.count_out !== 3'd2) begin n_fail++; $display("FAIL b2b_count%0d got %0d exp 2", i, bus.count_out); end
      advance();
    end
    bus.push_valid_in = 1'b0;
    bus.pop_ready_in  = 1'b0;
  endtask

  task automatic test_flush();
    clear_q();
    for (int i = 0; i < 3; i++) begin push_one($urandom, pc_ctr); pc_ctr += 4; end
    bus.push_valid_in = 1'b1;
    bus.push_instr_in = 32'h00100093;
    bus.pop_ready_in  = 1'b1;
    bus.flush_in      = 1'b1;
    settle();
    n_tests += 2;
    if (bus.pop_valid_out !== 1'b0) begin n_fail++; $display("FAIL flush_pop_valid got %0b exp 0", bus.pop_valid_out); end
    if (bus.opcode_out !== 7'h13) begin n_fail++; $display("FAIL flush_opcode got %h exp 13", bus.opcode_out); end
    advance();
    bus.flush_in      = 1'b0;
    bus.push_valid_in = 1'b0;
    bus.pop_ready_in  = 1'b0;
    settle();
    n_tests++;
    if (bus.count_out !== 3'd0) begin n_fail++; $display("FAIL flush_count got %0d exp 0", bus.count_out); end
    advance();
  endtask

  task automatic test_full_pop();
    clear_q();
    for (int i = 0; i < 4; i++) begin push_one($urandom, pc_ctr); pc_ctr += 4; end
    bus.pop_ready_in  = 1'b1;
    bus.push_valid_in = 1'b1;
    bus.push_instr_in = 32'h00000073;
    bus.push_pc_in    = pc_ctr; pc_ctr += 4;
    settle();
    n_tests++;
    if (bus.push_ready_out !== 1'b0) begin n_fail++; $display("FAIL full_pop_ready got %0b exp 0", bus.push_ready_out); end
    advance();
    settle();
    n_tests += 2;
    if (bus.count_out !== 3'd3) begin n_fail++; $display("FAIL full_pop_count got %0d exp 3", bus.count_out); end
    if (bus.push_ready_out !== 1'b1) begin n_fail++; $display("FAIL full_pop_ready_next got %0b exp 1", bus.push_ready_out); end
    advance();
    bus.push_valid_in = 1'b0;
    bus.pop_ready_in  = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      bus.push_valid_in = ($urandom_range(0, 3) != 0);
      bus.pop_ready_in  = ($urandom_range(0, 2) != 0);
      bus.flush_in      = ($urandom_range(0, 15) == 0);
      rst_n             = ($urandom_range(0, 63) != 0);
      bus.push_instr_in = $urandom;
      bus.push_pc_in    = pc_ctr; pc_ctr += 4;
      settle();
      advance();
    end
    rst_n         = 1'b1;
    bus.flush_in  = 1'b0;
    bus.push_valid_in = 1'b0;
    bus.pop_ready_in  = 1'b0;
  endtask

`ifdef MSRV32_IQ_ILLEGAL_CHECK_EN
  task automatic test_illegal();
    clear_q();
    push_one(32'hFFFFFFFF, 32'h100);
    settle();
    n_tests++;
    if (bus.illegal_out !== 1'b1) begin n_fail++; $display("FAIL illegal_ffff got %0b exp 1", bus.illegal_out); end
    bus.pop_ready_in = 1'b1;
    bus.push_valid_in = 1'b1;
    bus.push_instr_in = 32'h00000073;
    bus.push_pc_in    = 32'h104;
    advance();
    bus.pop_ready_in  = 1'b0;
    bus.push_valid_in = 1'b0;
    settle();
    n_tests++;
    if (bus.illegal_out !== 1'b0) begin n_fail++; $display("FAIL illegal_ecall got %0b exp 0", bus.illegal_out); end
    advance();
  endtask
`endif

  initial begin
    n_tests = 0;
    n_fail  = 0;
    model_known = 1'b0;
    pc_ctr  = 32'h1000;
    rst_n   = 1'b0;
    bus.flush_in      = 1'b0;
    bus.push_valid_in = 1'b0;
    bus.push_instr_in = '0;
    bus.push_pc_in    = '0;
    bus.pop_ready_in  = 1'b0;
    test_reset();
    test_fill_drain();
    test_back_to_back();
    test_flush();
    test_full_pop();
    test_random();
`ifdef MSRV32_IQ_ILLEGAL_CHECK_EN
    test_illegal();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
